// File: rtl/z80_blkcmp_pkg.sv
// rtl/z80_blkcmp_pkg.sv - shared types and constants for the Z80 block-compare sequencer
// Holds the sequencer state encoding, F register bit positions and the ED-group opcodes.
package z80_blkcmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_CALC   = 2'd2,
    ST_RETIRE = 2'd3
  } state_t;

  localparam int FLAG_S  = 7;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_5  = 5;
  localparam int FLAG_H  = 4;
  localparam int FLAG_3  = 3;
  localparam int FLAG_PV = 2;
  localparam int FLAG_N  = 1;
  localparam int FLAG_C  = 0;

  localparam logic [7:0] OPC_PREFIX = 8'hED;
  localparam logic [7:0] OPC_CPI    = 8'hA1;
  localparam logic [7:0] OPC_CPD    = 8'hA9;
  localparam logic [7:0] OPC_CPIR   = 8'hB1;
  localparam logic [7:0] OPC_CPDR   = 8'hB9;

  // HL steps by one in either direction and wraps at the 16-bit boundary.
  function automatic logic [15:0] step_hl(input logic [15:0] hl, input logic dec);
    return dec ? (hl - 16'd1) : (hl + 16'd1);
  endfunction

endpackage

// File: rtl/z80_blkcmp_alu.sv
// rtl/z80_blkcmp_alu.sv - combinational flag/pointer/counter update for one compare iteration
// Computes A-(HL) flags plus the decremented BC and stepped HL.
module z80_blkcmp_alu
  import z80_blkcmp_pkg::*;
(
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_m,
  input  logic [7:0]  i_f,
  input  logic [15:0] i_bc,
  input  logic [15:0] i_hl,
  input  logic        i_op_dec,
  output logic [7:0]  o_f,
  output logic [15:0] o_bc,
  output logic [15:0] o_hl
);

  logic [7:0] w_diff;

  always_comb begin
    w_diff = i_a - i_m;
    o_bc   = i_bc - 16'd1;
    o_hl   = step_hl(i_hl, i_op_dec);
    // Bits 5, 3 and C pass through from the incoming F.
    o_f          = i_f;
    o_f[FLAG_S]  = w_diff[7];
    o_f[FLAG_Z]  = (w_diff == 8'd0);
    o_f[FLAG_H]  = (i_a[3:0] < i_m[3:0]);
    o_f[FLAG_PV] = (o_bc != 16'd0);
    o_f[FLAG_N]  = 1'b1;
  end

endmodule

// File: rtl/z80_blkcmp_seq.sv
// rtl/z80_blkcmp_seq.sv - CPI/CPD/CPIR/CPDR micro-sequencer with optional Z80FI trace
// Optional trace record ports are built when Z80_BLKCMP_FI_EN is defined.
module z80_blkcmp_seq
  import z80_blkcmp_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_dec,
  input  logic        op_rep,
  input  logic [7:0]  a_in,
  input  logic [7:0]  f_in,
  input  logic [15:0] bc_in,
  input  logic [15:0] hl_in,
  input  logic [15:0] ip_in,
  input  logic        irq_pending,
  output logic        ready,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        done,
  output logic [15:0] bc_out,
  output logic [15:0] hl_out,
  output logic [7:0]  f_out,
  output logic [15:0] ip_out,
  output logic        err
`ifdef Z80_BLKCMP_FI_EN
  ,
  output logic        fi_valid,
  output logic [15:0] fi_ip_in,
  output logic [15:0] fi_ip_out,
  output logic [15:0] fi_bc_in,
  output logic [15:0] fi_bc_out,
  output logic [15:0] fi_hl_in,
  output logic [15:0] fi_hl_out,
  output logic [7:0]  fi_f_in,
  output logic [7:0]  fi_f_out,
  output logic [15:0] fi_mem_raddr,
  output logic [7:0]  fi_mem_rdata
`endif
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t            r_state;
  logic              r_op_dec;
  logic              r_op_rep;
  logic              r_loop;
  logic [7:0]        r_a;
  logic [7:0]        r_f;
  logic [7:0]        r_m;
  logic [15:0]       r_bc;
  logic [15:0]       r_hl;
  logic [15:0]       r_ip;
  logic [WAIT_W-1:0] r_wait;

  logic [7:0]  w_alu_f;
  logic [15:0] w_alu_bc;
  logic [15:0] w_alu_hl;
  logic        w_cont;
  logic        w_timeout;

  z80_blkcmp_alu u_alu (
    .i_a      (r_a),
    .i_m      (r_m),
    .i_f      (r_f),
    .i_bc     (r_bc),
    .i_hl     (r_hl),
    .i_op_dec (r_op_dec),
    .o_f      (w_alu_f),
    .o_bc     (w_alu_bc),
    .o_hl     (w_alu_hl)
  );

  assign w_cont    = r_op_rep & w_alu_f[FLAG_PV] & ~w_alu_f[FLAG_Z];
  assign w_timeout = (MEM_TIMEOUT != 0) && (r_wait == WAIT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_op_dec <= 1'b0;
      r_op_rep <= 1'b0;
      r_loop   <= 1'b0;
      r_a      <= 8'd0;
      r_f      <= 8'd0;
      r_m      <= 8'd0;
      r_bc     <= 16'd0;
      r_hl     <= 16'd0;
      r_ip     <= 16'd0;
      r_wait   <= '0;
      ready    <= 1'b1;
      mem_rd   <= 1'b0;
      mem_addr <= 16'd0;
      done     <= 1'b0;
      err      <= 1'b0;
      bc_out   <= 16'd0;
      hl_out   <= 16'd0;
      f_out    <= 8'd0;
      ip_out   <= 16'd0;
`ifdef Z80_BLKCMP_FI_EN
      fi_valid     <= 1'b0;
      fi_ip_in     <= 16'd0;
      fi_ip_out    <= 16'd0;
      fi_bc_in     <= 16'd0;
      fi_bc_out    <= 16'd0;
      fi_hl_in     <= 16'd0;
      fi_hl_out    <= 16'd0;
      fi_f_in      <= 8'd0;
      fi_f_out     <= 8'd0;
      fi_mem_raddr <= 16'd0;
      fi_mem_rdata <= 8'd0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
`ifdef Z80_BLKCMP_FI_EN
      fi_valid <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op_dec <= op_dec;
            r_op_rep <= op_rep;
            r_a      <= a_in;
            r_f      <= f_in;
            r_bc     <= bc_in;
            r_hl     <= hl_in;
            r_ip     <= ip_in;
            r_wait   <= '0;
            mem_rd   <= 1'b1;
            mem_addr <= hl_in;
            ready    <= 1'b0;
            r_state  <= ST_READ;
          end
        end

        ST_READ: begin
          if (mem_ack) begin
            r_m     <= mem_rdata;
            mem_rd  <= 1'b0;
            r_state <= ST_CALC;
          end else if (w_timeout) begin
            err     <= 1'b1;
            mem_rd  <= 1'b0;
            ready   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end

        ST_CALC: begin
          // The interrupt decision is taken here so done and the record are registered into RETIRE.
          bc_out  <= w_alu_bc;
          hl_out  <= w_alu_hl;
          f_out   <= w_alu_f;
          ip_out  <= w_cont ? r_ip : (r_ip + 16'd2);
          r_loop  <= w_cont & ~irq_pending;
          done    <= ~(w_cont & ~irq_pending);
          r_state <= ST_RETIRE;
`ifdef Z80_BLKCMP_FI_EN
          fi_valid     <= 1'b1;
          fi_ip_in     <= r_ip;
          fi_ip_out    <= w_cont ? r_ip : (r_ip + 16'd2);
          fi_bc_in     <= r_bc;
          fi_bc_out    <= w_alu_bc;
          fi_hl_in     <= r_hl;
          fi_hl_out    <= w_alu_hl;
          fi_f_in      <= r_f;
          fi_f_out     <= w_alu_f;
          fi_mem_raddr <= r_hl;
          fi_mem_rdata <= r_m;
`endif
        end

        ST_RETIRE: begin
          if (r_loop) begin
            r_bc     <= bc_out;
            r_hl     <= hl_out;
            r_f      <= f_out;
            r_wait   <= '0;
            mem_rd   <= 1'b1;
            mem_addr <= hl_out;
            r_state  <= ST_READ;
          end else begin
            ready   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_blkcmp_seq.sv
// tb/tb_z80_blkcmp_seq.sv - directed self-checking bench for z80_blkcmp_seq
module tb_z80_blkcmp_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op_dec;
  logic        op_rep;
  logic [7:0]  a_in;
  logic [7:0]  f_in;
  logic [15:0] bc_in;
  logic [15:0] hl_in;
  logic [15:0] ip_in;
  logic        irq_pending;
  logic        ready;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        done;
  logic [15:0] bc_out;
  logic [15:0] hl_out;
  logic [7:0]  f_out;
  logic [15:0] ip_out;
  logic        err;
`ifdef Z80_BLKCMP_FI_EN
  logic        fi_valid;
  logic [15:0] fi_ip_in, fi_ip_out, fi_bc_in, fi_bc_out, fi_hl_in, fi_hl_out, fi_mem_raddr;
  logic [7:0]  fi_f_in, fi_f_out, fi_mem_rdata;
`endif

  z80_blkcmp_seq #(.MEM_TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op_dec      (op_dec),
    .op_rep      (op_rep),
    .a_in        (a_in),
    .f_in        (f_in),
    .bc_in       (bc_in),
    .hl_in       (hl_in),
    .ip_in       (ip_in),
    .irq_pending (irq_pending),
    .ready       (ready),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .done        (done),
    .bc_out      (bc_out),
    .hl_out      (hl_out),
    .f_out       (f_out),
    .ip_out      (ip_out),
    .err         (err)
`ifdef Z80_BLKCMP_FI_EN
    ,
    .fi_valid     (fi_valid),
    .fi_ip_in     (fi_ip_in),
    .fi_ip_out    (fi_ip_out),
    .fi_bc_in     (fi_bc_in),
    .fi_bc_out    (fi_bc_out),
    .fi_hl_in     (fi_hl_in),
    .fi_hl_out    (fi_hl_out),
    .fi_f_in      (fi_f_in),
    .fi_f_out     (fi_f_out),
    .fi_mem_raddr (fi_mem_raddr),
    .fi_mem_rdata (fi_mem_rdata)
`endif
  );

  typedef struct {
    logic [15:0] ip_in, ip_out, bc_in, bc_out, hl_in, hl_out;
    logic [7:0]  f_in, f_out, rdata;
  } rec_t;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] exp_addr[$];
  rec_t        exp_rec[$];
  int          exp_nrec;
  logic [7:0]  exp_f;
  logic [15:0] exp_bc, exp_hl, exp_ip;
  int          reads, done_cnt, err_cnt, fi_cnt;
  int          resp_mode, resp_waits, resp_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Reference: walk the instruction iteration by iteration with plain arithmetic.
  task automatic model(input bit dec, input bit rep, input logic [7:0] a, input logic [7:0] f,
                       input logic [15:0] bc, input logic [15:0] hl, input logic [15:0] ip, input bit irq);
    logic [7:0] m, d, fn;
    logic [15:0] bcn, hln;
    bit z, v, cont;
    rec_t r;
    exp_addr.delete();
    exp_rec.delete();
    exp_nrec = 0;
    for (int it = 0; it < 65536; it++) begin
      m    = mem[hl];
      d    = a - m;
      z    = (d == 8'd0);
      bcn  = bc - 16'd1;
      v    = (bcn != 16'd0);
      hln  = dec ? hl - 16'd1 : hl + 16'd1;
      fn   = {d[7], z, f[5], (a[3:0] < m[3:0]), f[3], v, 1'b1, f[0]};
      cont = rep && v && !z;
      exp_addr.push_back(hl);
      r.ip_in = ip; r.ip_out = cont ? ip : ip + 16'd2;
      r.bc_in = bc; r.bc_out = bcn; r.hl_in = hl; r.hl_out = hln;
      r.f_in = f; r.f_out = fn; r.rdata = m;
      exp_rec.push_back(r);
      exp_nrec++;
      exp_f = fn; exp_bc = bcn; exp_hl = hln; exp_ip = r.ip_out;
      if (!cont || irq) break;
      bc = bcn; hl = hln; f = fn;
    end
  endtask

  // Memory responder: acknowledges after resp_waits wait cycles; mode 1 never acks, mode 2 forces ack.
  always begin
    @(posedge clk); #1;
    if (resp_mode == 2) begin
      mem_ack = 1'b1; mem_rdata = 8'hEE;
    end else if (mem_rd && resp_mode == 0) begin
      if (resp_cnt >= resp_waits) begin
        mem_ack = 1'b1; mem_rdata = mem[mem_addr];
      end else begin
        mem_ack = 1'b0; resp_cnt++;
      end
    end else begin
      mem_ack = 1'b0;
      if (!mem_rd) resp_cnt = 0;
    end
  end

  rec_t cr;
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_rd) begin
        if (exp_addr.size() == 0) chk("read_expected", 0, 1);
        else begin
          chk("mem_addr", mem_addr, exp_addr[0]);
          if (mem_ack) begin
            void'(exp_addr.pop_front());
            reads++;
          end
        end
      end
      if (done) begin
        done_cnt++;
        chk("f_out", f_out, exp_f);
        chk("bc_out", bc_out, exp_bc);
        chk("hl_out", hl_out, exp_hl);
        chk("ip_out", ip_out, exp_ip);
        chk("read_count", reads, exp_nrec);
      end
      if (err) err_cnt++;
`ifdef Z80_BLKCMP_FI_EN
      if (fi_valid) begin
        fi_cnt++;
        if (exp_rec.size() == 0) chk("fi_expected", 0, 1);
        else begin
          cr = exp_rec.pop_front();
          chk("fi_ip_in", fi_ip_in, cr.ip_in);
          chk("fi_ip_out", fi_ip_out, cr.ip_out);
          chk("fi_bc_in", fi_bc_in, cr.bc_in);
          chk("fi_bc_out", fi_bc_out, cr.bc_out);
          chk("fi_hl_in", fi_hl_in, cr.hl_in);
          chk("fi_hl_out", fi_hl_out, cr.hl_out);
          chk("fi_f_in", fi_f_in, cr.f_in);
          chk("fi_f_out", fi_f_out, cr.f_out);
          chk("fi_raddr", fi_mem_raddr, cr.hl_in);
          chk("fi_rdata", fi_mem_rdata, cr.rdata);
        end
      end
`endif
    end
  end

  task automatic run_instr(input bit dec, input bit rep, input logic [7:0] a, input logic [7:0] f,
                           input logic [15:0] bc, input logic [15:0] hl, input logic [15:0] ip,
                           input bit irq, input bit poke, output int cyc);
    model(dec, rep, a, f, bc, hl, ip, irq);
    reads = 0;
    resp_waits = 0;
    @(posedge clk); #1;
    op_dec = dec; op_rep = rep; a_in = a; f_in = f;
    bc_in = bc; hl_in = hl; ip_in = ip; start = 1'b1;
    cyc = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (irq && k == 1) irq_pending = 1'b1;
      if (poke && k == 1) begin
        start = 1'b1; hl_in = 16'h7777;
      end
      if (done) begin
        cyc = k;
        break;
      end
    end
    if (cyc < 0) chk("done_timeout", 0, 1);
    irq_pending = 1'b0;
    @(posedge clk); #1;
    chk("ready_after", ready, 1);
    chk("hl_hold", hl_out, exp_hl);
  endtask

  int cyc, snap_done, snap_fi, errcyc;

  initial begin
    reset = 1'b1; start = 1'b0; op_dec = 1'b0; op_rep = 1'b0;
    a_in = 8'd0; f_in = 8'd0; bc_in = 16'd0; hl_in = 16'd0; ip_in = 16'd0;
    irq_pending = 1'b0; mem_ack = 1'b0; mem_rdata = 8'd0;
    resp_mode = 0; resp_waits = 0; resp_cnt = 0;
    reads = 0; done_cnt = 0; err_cnt = 0; fi_cnt = 0; exp_nrec = 0;
    exp_f = 8'd0; exp_bc = 16'd0; exp_hl = 16'd0; exp_ip = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_bc", bc_out, 0);
    chk("rst_hl", hl_out, 0);
    chk("rst_f", f_out, 0);
    chk("rst_ip", ip_out, 0);
`ifdef Z80_BLKCMP_FI_EN
    chk("rst_fi_valid", fi_valid, 0);
    chk("rst_fi_hl_in", fi_hl_in, 0);
`endif
    reset = 1'b0;

    // CPI, match
    mem[16'h1000] = 8'h42;
    run_instr(0, 0, 8'h42, 8'h00, 16'h0005, 16'h1000, 16'h0100, 0, 0, cyc);
    chk("t1_cycles", cyc, 3);
    chk("t1_f", f_out, 8'h46);
    chk("t1_hl", hl_out, 16'h1001);
    chk("t1_bc", bc_out, 16'h0004);
    chk("t1_ip", ip_out, 16'h0102);

    // CPIR, match on third byte, with an ignored start while busy
    mem[16'h2000] = 8'h01; mem[16'h2001] = 8'h02; mem[16'h2002] = 8'h07;
    run_instr(0, 1, 8'h07, 8'h29, 16'h0010, 16'h2000, 16'h0200, 0, 1, cyc);
    chk("t2_cycles", cyc, 9);
    chk("t2_reads", reads, 3);
    chk("t2_f", f_out, 8'h6F);
    chk("t2_hl", hl_out, 16'h2003);
    chk("t2_bc", bc_out, 16'h000D);
    chk("t2_ip", ip_out, 16'h0202);

    // CPDR wrapping HL below zero, BC runs out
    mem[16'h0000] = 8'h55; mem[16'hFFFF] = 8'h55;
    run_instr(1, 1, 8'h00, 8'h00, 16'h0002, 16'h0000, 16'h0300, 0, 0, cyc);
    chk("t3_reads", reads, 2);
    chk("t3_hl", hl_out, 16'hFFFE);
    chk("t3_bc", bc_out, 16'h0000);
    chk("t3_f", f_out, 8'h92);
    chk("t3_ip", ip_out, 16'h0302);

    // CPIR interrupted after the first iteration
    mem[16'h3000] = 8'h00;
    run_instr(0, 1, 8'hFF, 8'h00, 16'h0003, 16'h3000, 16'h0400, 1, 0, cyc);
    chk("t4_reads", reads, 1);
    chk("t4_bc", bc_out, 16'h0002);
    chk("t4_ip", ip_out, 16'h0400);
    chk("t4_f", f_out, 8'h86);

    // Reset during a read with wait states; a late ack must be ignored
    snap_done = done_cnt; snap_fi = fi_cnt;
    mem[16'h4000] = 8'h33;
    model(0, 0, 8'h33, 8'h00, 16'h0001, 16'h4000, 16'h0500, 0);
    @(posedge clk); #1;
    resp_waits = 2;
    op_dec = 1'b0; op_rep = 1'b0; a_in = 8'h33; bc_in = 16'h0001; hl_in = 16'h4000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    chk("t5_mem_rd_wait", mem_rd, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t5_mem_rd_drop", mem_rd, 0);
    chk("t5_ready", ready, 1);
    reset = 1'b0;
    exp_addr.delete(); exp_rec.delete();
    resp_waits = 0; resp_mode = 2;
    repeat (2) begin
      @(posedge clk); #1;
      chk("t5_mem_rd_idle", mem_rd, 0);
      chk("t5_ready_idle", ready, 1);
    end
    resp_mode = 0;
    @(posedge clk); #1;
    chk("t5_no_done", done_cnt, snap_done);
    chk("t5_no_fi", fi_cnt, snap_fi);

    // Timeout: ack never arrives
    resp_mode = 1;
    snap_done = done_cnt;
    model(0, 0, 8'h00, 8'h00, 16'h0001, 16'h6000, 16'h0600, 0);
    @(posedge clk); #1;
    hl_in = 16'h6000; bc_in = 16'h0001; start = 1'b1;
    errcyc = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (err) begin
        errcyc = k;
        break;
      end
    end
    chk("t6_err_cycle", errcyc, 5);
    chk("t6_mem_rd", mem_rd, 0);
    chk("t6_ready", ready, 1);
    chk("t6_done", done, 0);
    @(posedge clk); #1;
    chk("t6_err_pulse", err, 0);
    chk("t6_err_cnt", err_cnt, 1);
    chk("t6_no_done", done_cnt, snap_done);
    exp_addr.delete(); exp_rec.delete();
    resp_mode = 0;

    // CPD after recovery; F bits 5, 3 and C pass through
    mem[16'h5000] = 8'h80;
    run_instr(1, 0, 8'h10, 8'hFF, 16'h0001, 16'h5000, 16'h0500, 0, 0, cyc);
    chk("t7_cycles", cyc, 3);
    chk("t7_f", f_out, 8'hAB);
    chk("t7_hl", hl_out, 16'h4FFF);
    chk("t7_bc", bc_out, 16'h0000);
    chk("t7_ip", ip_out, 16'h0502);

    chk("done_count", done_cnt, 5);
`ifdef Z80_BLKCMP_FI_EN
    chk("fi_count", fi_cnt, 8);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
